data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, handshaked successor to the single-cycle word data memory.
- Byte-addressed, big-endian RAM with byte, half and word loads and stores.
- Sign/zero extension on loads; alignment and range fault detection; configurable wait states.
- Sits between the MIPS datapath (or a future multicycle/pipelined control unit) and the data store.

Parameters:
- ADDR_WIDTH, 32, width of req_addr in bits.
- DEPTH_BYTES, 1024, RAM size in bytes. Must be a power of two and at least 4.
- WAIT_STATES, 0, extra cycles between request accept and the commit/response. Legal range 0..15.

Ports:
- clk  input  1  clock. All state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend. Ignored for word and for stores.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load result; 0 for stores and faults.
- resp_fault  output  1  request rejected, valid only with resp_valid.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at posedge: latch write, size, signed, addr and wdata.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Down-counter loaded with WAIT_STATES-1 on accept.
  - Leaves to RESP on the edge where the counter equals 0.
- Commit edge = the edge entering RESP. Store bytes and registered read data are both updated on that edge.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE unconditionally.
  - resp_rdata and resp_fault hold until the next commit; resp_valid returns to 0.
- Latency: resp_valid is high in cycle N+WAIT_STATES+1, where N is the accept edge. Throughput is one request per WAIT_STATES+2 cycles.
- Input fields changing after accept have no effect.
- Byte order is big-endian:
  - Word at address A is {M[A],M[A+1],M[A+2],M[A+3]}.
  - Half at A is {M[A],M[A+1]}.
- Store byte writes M[A]=wdata[7:0].
- Store half writes M[A]=wdata[15:8], M[A+1]=wdata[7:0].
- Loads:
  - Byte/half is extended to 32 bits per req_signed.
  - Word is returned unchanged.
- Fault conditions, any of:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr + bytes(size) > DEPTH_BYTES. Compute at ADDR_WIDTH+1 bits so there is no wrap.
- On fault: no RAM write, resp_rdata=0, resp_fault=1. The fault still consumes full latency.
- Reset asserted in WAIT before the commit edge: the store is discarded, no response is issued, RAM is unchanged.
- req_valid held high continuously: a new request is accepted only in IDLE. Back-to-back requests are separated by RESP.
- Read-after-write: a load accepted after a store's RESP returns the new data.

Test Plan:
- Reset + word store/load, WAIT_STATES=0:
  - Store 0xDEADBEEF @0x10 → resp_valid in accept+1, fault 0.
  - Load word @0x10 → rdata 0xDEADBEEF.
- Sub-word loads after the store above:
  - lb @0x10 signed → 0xFFFFFFDE.
  - lbu @0x13 → 0x000000EF.
  - lh @0x12 signed → 0xFFFFBEEF.
  - lhu @0x10 → 0x0000DEAD.
- Sub-word stores:
  - sb 0x12 @0x11, then word load @0x10 → 0xDE12BEEF.
  - sh 0xAB01 @0x12 → 0xDE12AB01.
- Faults:
  - Word load @0x11 → fault 1, rdata 0.
  - Half store @0x13 → fault 1, word @0x10 unchanged.
  - Word @DEPTH_BYTES-2 → fault.
  - size=11 → fault.
- WAIT_STATES=3:
  - req_ready=0 for cycles accept+1..accept+4.
  - resp_valid exactly at accept+4.
  - req_valid held high → second accept at accept+5.
- Reset mid-op, WAIT_STATES=3:
  - Store 0x11223344 @0x20, drop rst_n at accept+2.
  - No resp_valid, outputs at reset values.
  - Later load @0x20 returns the prior contents.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressed big-endian data RAM with byte/half/word access,
// load extension, alignment/range fault detection and configurable wait states.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [7:0] mem [DEPTH_BYTES];

  logic                  op_write;
  logic [1:0]            op_size;
  logic                  op_signed;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [31:0]           op_wdata;
  logic [ADDR_WIDTH:0]   span;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  fault;
  logic                  commit;
  logic [IDX_W-1:0]      b0, b1, b2, b3;
  logic [31:0]           load_data;

  // With no wait states the accept edge is also the commit edge, so the
  // operation is taken straight from the request inputs while idle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    op_write  = write_q;
    op_size   = size_q;
    op_signed = signed_q;
    op_addr   = addr_q;
    op_wdata  = wdata_q;
    if (state == S_IDLE) begin
      op_write  = req_write;
      op_size   = req_size;
      op_signed = req_signed;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
    end
  end

  always_comb begin
    span = '0;
    case (op_size)
      2'b00:   span = (ADDR_WIDTH + 1)'(1);
      2'b01:   span = (ADDR_WIDTH + 1)'(2);
      default: span = (ADDR_WIDTH + 1)'(4);
    endcase
  end

  // The extra top bit keeps the end address from wrapping near the top of the map.
  assign end_addr = {1'b0, op_addr} + span;
  assign fault    = (op_size == 2'b11)
                 || (op_size == 2'b01 && op_addr[0])
                 || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
                 || (end_addr > DEPTH_EXT);

  assign commit = rst_n && (((state == S_IDLE) && req_valid && (WAIT_STATES == 0))
                         || ((state == S_WAIT) && (cnt == 4'd0)));

  assign b0 = op_addr[IDX_W-1:0];
  assign b1 = b0 + IDX_W'(1);
  assign b2 = b0 + IDX_W'(2);
  assign b3 = b0 + IDX_W'(3);

  always_comb begin
    load_data = {mem[b0], mem[b1], mem[b2], mem[b3]};
    case (op_size)
      2'b00:   load_data = {{24{op_signed & mem[b0][7]}}, mem[b0]};
      2'b01:   load_data = {{16{op_signed & mem[b0][7]}}, mem[b0], mem[b1]};
      default: ;
    endcase
  end

  // NOTE: the RAM array has no reset; clearing it would cost a write port per
  // byte and its contents must survive a controller reset anyway.
  always_ff @(posedge clk) begin
    if (commit && op_write && !fault) begin
      case (op_size)
        2'b00: mem[b0] <= op_wdata[7:0];
        2'b01: begin
          mem[b0] <= op_wdata[15:8];
          mem[b1] <= op_wdata[7:0];
        end
        2'b10: begin
          mem[b0] <= op_wdata[31:24];
          mem[b1] <= op_wdata[23:16];
          mem[b2] <= op_wdata[15:8];
          mem[b3] <= op_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (commit) begin
        resp_valid <= 1'b1;
        resp_fault <= fault;
        resp_rdata <= (fault || op_write) ? 32'd0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: one instance with no wait states for
// the data path, one with three wait states for timing and mid-op reset.
module tb_data_memory_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, req_valid0, req_ready0, req_write0, req_signed0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0, resp_rdata0;
  logic        resp_valid0, resp_fault0;

  logic        rst_n3, req_valid3, req_ready3, req_write3, req_signed3;
  logic [1:0]  req_size3;
  logic [31:0] req_addr3, req_wdata3, resp_rdata3;
  logic        resp_valid3, resp_fault3;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write0), .req_size(req_size0), .req_signed(req_signed0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_fault(resp_fault0)
  );

  data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_size(req_size3), .req_signed(req_signed3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .resp_valid(resp_valid3),
    .resp_rdata(resp_rdata3), .resp_fault(resp_fault3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid0 === 1'b1) begin
      if (q0.size() == 0) check("spurious0", 32'(resp_valid0), 32'd0);
      else begin
        e0 = q0.pop_front();
        check({e0.tag, "_rdata"}, resp_rdata0, e0.rdata);
        check({e0.tag, "_fault"}, 32'(resp_fault0), 32'(e0.fault));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid3 === 1'b1) begin
      if (q3.size() == 0) check("spurious3", 32'(resp_valid3), 32'd0);
      else begin
        e3 = q3.pop_front();
        check({e3.tag, "_rdata"}, resp_rdata3, e3.rdata);
        check({e3.tag, "_fault"}, 32'(resp_fault3), 32'(e3.fault));
      end
    end
  end

  // Issue one request on the zero-wait instance; called and returns on a negedge.
  task automatic req0(input string tag, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_fault);
    int n = 0;
    while (req_ready0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, 32'(req_ready0), 32'd1);
    req_valid0  = 1'b1;
    req_write0  = wr;
    req_size0   = sz;
    req_signed0 = sg;
    req_addr0   = addr;
    req_wdata0  = wdata;
    q0.push_back('{tag, exp_rdata, exp_fault});
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    check({tag, "_latency"}, 32'(resp_valid0), 32'd1);
  endtask

  task automatic wait_ready3(input string tag);
    int n = 0;
    while (req_ready3 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({tag, "_ready_timeout"}, 32'(req_ready3), 32'd1);
  endtask

  initial begin
    int n;
    rst_n0 = 1'b0; rst_n3 = 1'b0;
    req_valid0 = 0; req_write0 = 0; req_size0 = 0; req_signed0 = 0; req_addr0 = 0; req_wdata0 = 0;
    req_valid3 = 0; req_write3 = 0; req_size3 = 0; req_signed3 = 0; req_addr3 = 0; req_wdata3 = 0;
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(req_ready0), 32'd1);
    check("rst_valid0", 32'(resp_valid0), 32'd0);
    check("rst_rdata0", resp_rdata0, 32'd0);
    check("rst_fault0", 32'(resp_fault0), 32'd0);
    check("rst_ready3", 32'(req_ready3), 32'd1);
    rst_n0 = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);

    // Word store/load and sub-word loads.
    req0("sw_10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0);
    req0("lw_10",  0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
    req0("lb_10",  0, 2'b00, 1, 32'h10, 32'h0,        32'hFFFFFFDE, 0);
    req0("lbu_13", 0, 2'b00, 0, 32'h13, 32'h0,        32'h000000EF, 0);
    req0("lh_12",  0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFBEEF, 0);
    req0("lhu_10", 0, 2'b01, 0, 32'h10, 32'h0,        32'h0000DEAD, 0);
    // Sub-word stores.
    req0("sb_11",  1, 2'b00, 0, 32'h11, 32'hFFFFFF12, 32'h0,        0);
    req0("lw_sb",  0, 2'b10, 0, 32'h10, 32'h0,        32'hDE12BEEF, 0);
    req0("sh_12",  1, 2'b01, 0, 32'h12, 32'h0000AB01, 32'h0,        0);
    req0("lw_sh",  0, 2'b10, 0, 32'h10, 32'h0,        32'hDE12AB01, 0);
    @(negedge clk);
    check("hold_rdata", resp_rdata0, 32'hDE12AB01);
    check("hold_valid", 32'(resp_valid0), 32'd0);
    // Faults and range boundary.
    req0("lw_mis",   0, 2'b10, 0, 32'h11,  32'h0,        32'h0,        1);
    req0("sh_mis",   1, 2'b01, 0, 32'h13,  32'h00005555, 32'h0,        1);
    req0("lw_after", 0, 2'b10, 0, 32'h10,  32'h0,        32'hDE12AB01, 0);
    req0("sw_top",   1, 2'b10, 0, 32'h3FC, 32'h01828384, 32'h0,        0);
    req0("lw_top",   0, 2'b10, 0, 32'h3FC, 32'h0,        32'h01828384, 0);
    req0("lh_top",   0, 2'b01, 1, 32'h3FE, 32'h0,        32'hFFFF8384, 0);
    req0("lw_over",  0, 2'b10, 0, 32'h3FE, 32'h0,        32'h0,        1);
    req0("lw_range", 0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1);
    req0("lb_range", 0, 2'b00, 0, 32'hFFFFFFFF, 32'h0,   32'h0,        1);
    req0("size_11",  0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1);

    // Wait-state timing with req_valid held high across two requests.
    wait_ready3("ws3_first");
    req_valid3 = 1'b1; req_write3 = 1'b1; req_size3 = 2'b10;
    req_addr3 = 32'h20; req_wdata3 = 32'hCAFEF00D;
    q3.push_back('{"ws3_sw", 32'h0, 1'b0});
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_write3 = 1'b0; req_wdata3 = 32'h0;
        q3.push_back('{"ws3_lw", 32'hCAFEF00D, 1'b0});
      end
      check($sformatf("ws3_busy_%0d", k), 32'(req_ready3), 32'd0);
      check($sformatf("ws3_valid_%0d", k), 32'(resp_valid3), (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("ws3_ready_again", 32'(req_ready3), 32'd1);
    @(negedge clk);
    check("ws3_second_accept", 32'(req_ready3), 32'd0);
    req_valid3 = 1'b0;

    // Reset in the middle of a store: no response, RAM unchanged.
    wait_ready3("ws3_rst");
    req_valid3 = 1'b1; req_write3 = 1'b1; req_size3 = 2'b10;
    req_addr3 = 32'h20; req_wdata3 = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_novalid_%0d", k), 32'(resp_valid3), 32'd0);
    end
    check("rst_mid_ready", 32'(req_ready3), 32'd1);
    check("rst_mid_rdata", resp_rdata3, 32'd0);
    check("rst_mid_fault", 32'(resp_fault3), 32'd0);
    rst_n3 = 1'b1;
    @(negedge clk);
    wait_ready3("ws3_reload");
    req_valid3 = 1'b1; req_write3 = 1'b0; req_size3 = 2'b10; req_addr3 = 32'h20;
    q3.push_back('{"ws3_lw_after_rst", 32'hCAFEF00D, 1'b0});
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;

    n = 0;
    while ((q0.size() != 0 || q3.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
